plic_claim_ctrl: RTL and testbench
==================================

Name: plic_claim_ctrl

Overview:
Per-target PLIC claim/complete controller. It owns the per-source interrupt gateways (pending/in-flight state) and a registered priority fan-in that selects the highest-priority enabled pending source. It compares that selection against the target threshold to drive the external interrupt line. It sequences the hart's claim and complete handshakes.

Parameters:
NSRC, 4, number of interrupt sources; IDs are 1..NSRC and ID 0 means "no interrupt"
PRIO_W, 2, priority width in bits; priority 0 means "never interrupt"
IDW, $clog2(NSRC+1), width of the source ID field (derived, not overridable)

Ports:
clock  in  1  single clock for the block
reset  in  1  synchronous, active-low reset; block is in reset while reset==0 at a rising clock edge
io_src_irq  in  NSRC  level interrupt inputs; bit i-1 is source i
io_prio  in  NSRC*PRIO_W  per-source priority; source i is field [i*PRIO_W-1 -: PRIO_W]
io_enable  in  NSRC  per-source enable for this target
io_threshold  in  PRIO_W  target threshold
io_claim_req  in  1  claim request pulse
io_claim_ack  out  1  claim response valid, one-cycle pulse
io_claim_id  out  IDW  claimed ID; valid with io_claim_ack, 0 if none
io_complete_valid  in  1  completion strobe
io_complete_id  in  IDW  ID being completed
io_eip  out  1  external interrupt pending to the hart
io_pending  out  NSRC  gateway pending bits, for the pending-register read path

Behaviour:
- Reset (reset==0 at an edge): all gateways IDLE, io_pending=0, io_eip=0, io_claim_ack=0, io_claim_id=0, claim FSM IDLE, fan-in registers cleared to ID 0 / priority 0.
- Gateway per source, states IDLE / PENDING / INFLIGHT:
  - IDLE -> PENDING when io_src_irq=1; the pending bit is visible the next cycle.
  - PENDING -> INFLIGHT when this source is claimed.
  - INFLIGHT -> IDLE on io_complete_valid with io_complete_id equal to this source.
  - In PENDING and INFLIGHT, io_src_irq is ignored.
  - io_pending[i-1] = (state==PENDING).
- Fan-in, registered with 1-cycle latency:
  - Candidate set is sources with pending & enable & prio!=0.
  - Selects the maximum priority; ties go to the lowest ID.
  - Registers best_id and best_prio; best_id=0 and best_prio=0 when there is no candidate.
- io_eip is registered from the fan-in output: io_eip = (best_prio > io_threshold), strict compare. Total latency from irq rise to io_eip is 2 cycles.
- Claim FSM, states IDLE / RESP:
  - IDLE & io_claim_req -> RESP. The current registered best_id is sampled as claim_id.
  - If claim_id!=0, that gateway goes PENDING->INFLIGHT on the same edge.
  - RESP: io_claim_ack=1 and io_claim_id=claim_id for exactly one cycle, then -> IDLE.
  - io_claim_req while in RESP is dropped, with no state effect.
  - The claim uses the fan-in value registered before the edge. The claim does not compare against the threshold: a source at or below the threshold is still claimable.
- Complete:
  - Applied in any claim FSM state.
  - ID 0, ID > NSRC, or an ID not INFLIGHT is ignored silently.
- Simultaneous events:
  - Complete plus irq on the same source: the source goes IDLE this edge and PENDING on the next edge if irq is still high.
  - Claim plus complete on different IDs: both take effect on the same edge.
  - Claim plus disable of the claimed source on the same cycle: the claim still succeeds, because it is based on the registered best_id.
- After a claim, the fan-in removes the claimed source from its candidates on the following cycle. io_eip may therefore stay high for one extra cycle; this is permitted and the hart tolerates it.
- Reset asserted mid-claim: the RESP pulse is suppressed and all gateways return to IDLE.

Optional Feature:
PLIC_EDGE_EN
- Defined: gateways are edge-triggered.
  - Each source registers io_src_irq and detects a rising edge (irq & ~irq_q).
  - A rising edge in IDLE -> PENDING.
  - Rising edges in PENDING or INFLIGHT increment a per-source 2-bit saturating counter (max 3).
  - On completion with counter>0: the gateway goes INFLIGHT->PENDING directly and the counter decrements.
  - On completion with counter==0: INFLIGHT->IDLE.
  - Reset clears irq_q and the counters.
- Undefined: level behaviour as above. No counters or edge registers are instantiated.

Test Plan:
- Single source: NSRC=4, src2 prio=2, enabled, threshold=0, raise irq2.
  - io_pending=4'b0010 after 1 cycle, io_eip=1 after 2 cycles.
  - Claim -> ack 1 cycle later with id=2; pending=0.
  - Complete id=2 with irq still high -> PENDING again on the next edge.
- Priority and ties: prio src1=1, src3=3, src4=3, all pending.
  - Claims return 3, then 4, then 1, then 0 (ack with id=0, no state change).
- Threshold: single pending src1 prio=2.
  - Threshold 2 -> io_eip=0; threshold 1 -> io_eip=1.
  - Claim with threshold 3 still returns id=1.
- Bad completes: src1 INFLIGHT.
  - Complete id=0, id=5 and id=2 -> no change.
  - Complete id=1 -> IDLE.
  - Back-to-back claim_req in RESP -> a single ack.
- Reset mid-operation: reset=0 during RESP with two sources INFLIGHT.
  - Next cycle: ack=0, pending=0, eip=0.
  - After release, sources re-pend within 1 cycle if irq is high.
- PLIC_EDGE_EN: three rising edges on src1 while INFLIGHT, then completes.
  - Src1 re-pends 3 times and then goes IDLE.
  - A fourth edge while the counter is saturated is lost.

Source files
------------

// File: rtl/plic_claim_ctrl.sv
// Per-target PLIC claim/complete controller: source gateways, registered priority
// fan-in, threshold compare and claim/complete sequencing. Define PLIC_EDGE_EN for edge gateways.
module plic_claim_ctrl #(
  parameter  int NSRC   = 4,
  parameter  int PRIO_W = 2,
  localparam int IDW    = $clog2(NSRC + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NSRC-1:0]        io_src_irq,
  input  logic [NSRC*PRIO_W-1:0] io_prio,
  input  logic [NSRC-1:0]        io_enable,
  input  logic [PRIO_W-1:0]      io_threshold,
  input  logic                   io_claim_req,
  output logic                   io_claim_ack,
  output logic [IDW-1:0]         io_claim_id,
  input  logic                   io_complete_valid,
  input  logic [IDW-1:0]         io_complete_id,
  output logic                   io_eip,
  output logic [NSRC-1:0]        io_pending
);

  typedef enum logic [1:0] {GW_IDLE = 2'd0, GW_PEND = 2'd1, GW_INFL = 2'd2} gw_e;
  typedef enum logic {CL_IDLE = 1'b0, CL_RESP = 1'b1} cl_e;

  gw_e               gw_q [NSRC];
  gw_e               gw_d [NSRC];
  cl_e               cl_q, cl_d;
  logic [IDW-1:0]    claim_id_q, claim_id_d;
  logic [IDW-1:0]    best_id_q, best_id_d;
  logic [PRIO_W-1:0] best_prio_q, best_prio_d;
  logic              eip_q, eip_d;
  logic              claim_fire;
  logic [NSRC-1:0]   claim_hit, cmp_hit;

`ifdef PLIC_EDGE_EN
  logic [NSRC-1:0] irq_q;
  logic [1:0]      cnt_q [NSRC];
  logic [1:0]      cnt_d [NSRC];
  logic [NSRC-1:0] rise;

  assign rise = io_src_irq & ~irq_q;
`endif

  // Claim sequencing samples the fan-in value registered before this edge.
  always_comb begin
    cl_d       = cl_q;
    claim_id_d = claim_id_q;
    claim_fire = 1'b0;
    case (cl_q)
      CL_IDLE: if (io_claim_req) begin
        claim_fire = 1'b1;
        claim_id_d = best_id_q;
        cl_d       = CL_RESP;
      end
      CL_RESP: cl_d = CL_IDLE;
      default: cl_d = CL_IDLE;
    endcase
  end

  // Out-of-range and zero completion IDs match no source and fall through.
  always_comb begin
    claim_hit = '0;
    cmp_hit   = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_hit[i] = claim_fire && (best_id_q == IDW'(i + 1));
      cmp_hit[i]   = io_complete_valid && (io_complete_id == IDW'(i + 1));
    end
  end

  always_comb begin
`ifdef PLIC_EDGE_EN
    logic [1:0] cnt_inc;
`endif
    for (int i = 0; i < NSRC; i++) begin
      gw_d[i] = gw_q[i];
`ifdef PLIC_EDGE_EN
      cnt_inc  = cnt_q[i] + {1'b0, rise[i] & (cnt_q[i] != 2'd3)};
      cnt_d[i] = cnt_inc;
      case (gw_q[i])
        GW_IDLE: begin
          cnt_d[i] = cnt_q[i];
          if (rise[i]) gw_d[i] = GW_PEND;
        end
        GW_PEND: if (claim_hit[i]) gw_d[i] = GW_INFL;
        GW_INFL: if (cmp_hit[i]) begin
          if (cnt_inc != 2'd0) begin
            gw_d[i]  = GW_PEND;
            cnt_d[i] = cnt_inc - 2'd1;
          end else begin
            gw_d[i] = GW_IDLE;
          end
        end
        default: gw_d[i] = GW_IDLE;
      endcase
`else
      case (gw_q[i])
        GW_IDLE: if (io_src_irq[i]) gw_d[i] = GW_PEND;
        GW_PEND: if (claim_hit[i]) gw_d[i] = GW_INFL;
        GW_INFL: if (cmp_hit[i]) gw_d[i] = GW_IDLE;
        default: gw_d[i] = GW_IDLE;
      endcase
`endif
    end
  end

  // Ascending scan with strict compare keeps the lowest ID on priority ties.
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (gw_q[i] == GW_PEND && io_enable[i] &&
          io_prio[i*PRIO_W +: PRIO_W] > best_prio_d) begin
        best_prio_d = io_prio[i*PRIO_W +: PRIO_W];
        best_id_d   = IDW'(i + 1);
      end
    end
    eip_d = best_prio_d > io_threshold;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NSRC; i++) gw_q[i] <= GW_IDLE;
      cl_q        <= CL_IDLE;
      claim_id_q  <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      eip_q       <= 1'b0;
`ifdef PLIC_EDGE_EN
      irq_q <= '0;
      for (int i = 0; i < NSRC; i++) cnt_q[i] <= 2'd0;
`endif
    end else begin
      for (int i = 0; i < NSRC; i++) gw_q[i] <= gw_d[i];
      cl_q        <= cl_d;
      claim_id_q  <= claim_id_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      eip_q       <= eip_d;
`ifdef PLIC_EDGE_EN
      irq_q <= io_src_irq;
      for (int i = 0; i < NSRC; i++) cnt_q[i] <= cnt_d[i];
`endif
    end
  end

  always_comb begin
    io_pending = '0;
    for (int i = 0; i < NSRC; i++) io_pending[i] = (gw_q[i] == GW_PEND);
  end

  assign io_claim_ack = (cl_q == CL_RESP);
  assign io_claim_id  = (cl_q == CL_RESP) ? claim_id_q : '0;
  assign io_eip       = eip_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Bench for plic_claim_ctrl: directed vector table, hand sequences for reset and
// edge-mode corners, and randomized traffic against a rule-level reference model.
module tb_plic_claim_ctrl;
  localparam int NSRC = 4;
  localparam int PRIO_W = 2;
  localparam int IDW = 3;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [NSRC-1:0]        io_src_irq = '0;
  logic [NSRC*PRIO_W-1:0] io_prio = '0;
  logic [NSRC-1:0]        io_enable = '0;
  logic [PRIO_W-1:0]      io_threshold = '0;
  logic                   io_claim_req = 1'b0;
  logic                   io_claim_ack;
  logic [IDW-1:0]         io_claim_id;
  logic                   io_complete_valid = 1'b0;
  logic [IDW-1:0]         io_complete_id = '0;
  logic                   io_eip;
  logic [NSRC-1:0]        io_pending;

  plic_claim_ctrl #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
    .clock(clock), .reset(reset), .io_src_irq(io_src_irq), .io_prio(io_prio),
    .io_enable(io_enable), .io_threshold(io_threshold), .io_claim_req(io_claim_req),
    .io_claim_ack(io_claim_ack), .io_claim_id(io_claim_id),
    .io_complete_valid(io_complete_valid), .io_complete_id(io_complete_id),
    .io_eip(io_eip), .io_pending(io_pending)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit rst; logic [3:0] irq; logic [7:0] prio; logic [3:0] en; logic [1:0] thr;
    bit claim; bit cv; logic [2:0] cid;
    logic [3:0] e_pend; bit e_eip; bit e_ack; logic [2:0] e_id;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [3:0] irq, logic [7:0] prio, logic [3:0] en,
                              logic [1:0] thr, bit claim, bit cv, logic [2:0] cid,
                              logic [3:0] ep, bit ee, bit ea, logic [2:0] eid);
    vec_t v;
    v.rst = rst; v.irq = irq; v.prio = prio; v.en = en; v.thr = thr;
    v.claim = claim; v.cv = cv; v.cid = cid;
    v.e_pend = ep; v.e_eip = ee; v.e_ack = ea; v.e_id = eid;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input logic [3:0] irq, input logic [7:0] prio,
                       input logic [3:0] en, input logic [1:0] thr, input bit claim,
                       input bit cv, input logic [2:0] cid);
    reset = ~rst; io_src_irq = irq; io_prio = prio; io_enable = en; io_threshold = thr;
    io_claim_req = claim; io_complete_valid = cv; io_complete_id = cid;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] p, input bit e,
                            input bit a, input logic [2:0] id);
    chk({tag, "_pending"}, int'(io_pending), int'(p));
    chk({tag, "_eip"}, int'(io_eip), int'(e));
    chk({tag, "_ack"}, int'(io_claim_ack), int'(a));
    chk({tag, "_id"}, int'(io_claim_id), int'(id));
  endtask

  // Reference model: gateway state per source ID (0 idle, 1 pending, 2 in flight).
  int ms [NSRC+1];
  int mbid, mbp, mresp, mcid;
  bit meip;

  task automatic model_step();
    int old [NSRC+1];
    int bp, bid, p;
    bit fire;
    if (!reset) begin
      for (int s = 0; s <= NSRC; s++) ms[s] = 0;
      mbid = 0; mbp = 0; mresp = 0; mcid = 0; meip = 0;
      return;
    end
    old = ms;
    bp = 0; bid = 0;
    for (int s = 1; s <= NSRC; s++) begin
      p = int'(io_prio[(s-1)*PRIO_W +: PRIO_W]);
      if (old[s] == 1 && io_enable[s-1] && p > bp) begin bp = p; bid = s; end
    end
    fire = (mresp == 0) && io_claim_req;
    if (fire && mbid != 0 && old[mbid] == 1) ms[mbid] = 2;
    if (io_complete_valid && io_complete_id >= 1 && io_complete_id <= NSRC &&
        old[io_complete_id] == 2) ms[io_complete_id] = 0;
    for (int s = 1; s <= NSRC; s++) if (old[s] == 0 && io_src_irq[s-1]) ms[s] = 1;
    if (fire) mcid = mbid;
    mresp = fire ? 1 : 0;
    mbid = bid; mbp = bp;
    meip = bp > int'(io_threshold);
  endtask

  vec_t vecs [29];

  initial begin
    drive(1, 4'b0, 8'h0, 4'b0, 2'd0, 0, 0, 3'd0);
    tick();
    tick();
    expect_out("reset", 4'b0, 0, 0, 3'd0);

`ifdef PLIC_EDGE_EN
    drive(1, 4'b0, 8'h01, 4'b0001, 2'd0, 0, 0, 3'd0); tick();
    drive(0, 4'b0000, 8'h01, 4'b0001, 2'd0, 0, 0, 3'd0); tick();
    drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 0, 0, 3'd0); tick();
    chk("edge_first_pend", int'(io_pending), 1);
    tick();
    drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 1, 0, 3'd0); tick();
    chk("edge_claim_ack", int'(io_claim_ack), 1);
    chk("edge_claim_id", int'(io_claim_id), 1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 4'b0000, 8'h01, 4'b0001, 2'd0, 0, 0, 3'd0); tick();
      drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 0, 0, 3'd0); tick();
      chk("edge_inflight_quiet", int'(io_pending), 0);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 0, 1, 3'd1); tick();
      chk("edge_repend", int'(io_pending), 1);
      drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 0, 0, 3'd0); tick();
      drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 1, 0, 3'd0); tick();
      chk("edge_reclaim_id", int'(io_claim_id), 1);
      chk("edge_reclaim_pend", int'(io_pending), 0);
      drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 0, 0, 3'd0); tick();
    end
    drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 0, 1, 3'd1); tick();
    chk("edge_final_idle", int'(io_pending), 0);
    drive(0, 4'b0001, 8'h01, 4'b0001, 2'd0, 0, 0, 3'd0); tick();
    chk("edge_final_idle2", int'(io_pending), 0);
`else
    vecs[0]  = mk(0, 4'b0010, 8'h08, 4'b0010, 2'd0, 0, 0, 3'd0, 4'b0010, 0, 0, 3'd0);
    vecs[1]  = mk(0, 4'b0010, 8'h08, 4'b0010, 2'd0, 0, 0, 3'd0, 4'b0010, 1, 0, 3'd0);
    vecs[2]  = mk(0, 4'b0010, 8'h08, 4'b0010, 2'd0, 1, 0, 3'd0, 4'b0000, 1, 1, 3'd2);
    vecs[3]  = mk(0, 4'b0010, 8'h08, 4'b0010, 2'd0, 0, 0, 3'd0, 4'b0000, 0, 0, 3'd0);
    vecs[4]  = mk(0, 4'b0010, 8'h08, 4'b0010, 2'd0, 0, 1, 3'd2, 4'b0000, 0, 0, 3'd0);
    vecs[5]  = mk(0, 4'b0010, 8'h08, 4'b0010, 2'd0, 0, 0, 3'd0, 4'b0010, 0, 0, 3'd0);
    vecs[6]  = mk(0, 4'b0000, 8'h08, 4'b0010, 2'd0, 0, 0, 3'd0, 4'b0010, 1, 0, 3'd0);
    vecs[7]  = mk(1, 4'b0000, 8'hF1, 4'b1111, 2'd0, 0, 0, 3'd0, 4'b0000, 0, 0, 3'd0);
    vecs[8]  = mk(0, 4'b1101, 8'hF1, 4'b1111, 2'd0, 0, 0, 3'd0, 4'b1101, 0, 0, 3'd0);
    vecs[9]  = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 0, 0, 3'd0, 4'b1101, 1, 0, 3'd0);
    vecs[10] = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 1, 0, 3'd0, 4'b1001, 1, 1, 3'd3);
    vecs[11] = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 1, 0, 3'd0, 4'b1001, 1, 0, 3'd0);
    vecs[12] = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 1, 0, 3'd0, 4'b0001, 1, 1, 3'd4);
    vecs[13] = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 0, 0, 3'd0, 4'b0001, 1, 0, 3'd0);
    vecs[14] = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 1, 0, 3'd0, 4'b0000, 1, 1, 3'd1);
    vecs[15] = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 0, 0, 3'd0, 4'b0000, 0, 0, 3'd0);
    vecs[16] = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 1, 0, 3'd0, 4'b0000, 0, 1, 3'd0);
    vecs[17] = mk(0, 4'b0000, 8'hF1, 4'b1111, 2'd0, 0, 0, 3'd0, 4'b0000, 0, 0, 3'd0);
    vecs[18] = mk(1, 4'b0000, 8'h02, 4'b0001, 2'd2, 0, 0, 3'd0, 4'b0000, 0, 0, 3'd0);
    vecs[19] = mk(0, 4'b0001, 8'h02, 4'b0001, 2'd2, 0, 0, 3'd0, 4'b0001, 0, 0, 3'd0);
    vecs[20] = mk(0, 4'b0000, 8'h02, 4'b0001, 2'd2, 0, 0, 3'd0, 4'b0001, 0, 0, 3'd0);
    vecs[21] = mk(0, 4'b0000, 8'h02, 4'b0001, 2'd1, 0, 0, 3'd0, 4'b0001, 1, 0, 3'd0);
    vecs[22] = mk(0, 4'b0000, 8'h02, 4'b0001, 2'd3, 1, 0, 3'd0, 4'b0000, 0, 1, 3'd1);
    vecs[23] = mk(0, 4'b0000, 8'h02, 4'b0001, 2'd3, 0, 0, 3'd0, 4'b0000, 0, 0, 3'd0);
    vecs[24] = mk(0, 4'b0001, 8'h02, 4'b0001, 2'd3, 0, 1, 3'd0, 4'b0000, 0, 0, 3'd0);
    vecs[25] = mk(0, 4'b0001, 8'h02, 4'b0001, 2'd3, 0, 1, 3'd5, 4'b0000, 0, 0, 3'd0);
    vecs[26] = mk(0, 4'b0001, 8'h02, 4'b0001, 2'd3, 0, 1, 3'd2, 4'b0000, 0, 0, 3'd0);
    vecs[27] = mk(0, 4'b0001, 8'h02, 4'b0001, 2'd3, 0, 1, 3'd1, 4'b0000, 0, 0, 3'd0);
    vecs[28] = mk(0, 4'b0001, 8'h02, 4'b0001, 2'd3, 0, 0, 3'd0, 4'b0001, 0, 0, 3'd0);

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].rst, vecs[i].irq, vecs[i].prio, vecs[i].en, vecs[i].thr,
            vecs[i].claim, vecs[i].cv, vecs[i].cid);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_eip,
                 vecs[i].e_ack, vecs[i].e_id);
    end

    // Reset during a claim response with two sources in flight.
    drive(1, 4'b0011, 8'h55, 4'b1111, 2'd0, 0, 0, 3'd0); tick();
    drive(0, 4'b0011, 8'h55, 4'b1111, 2'd0, 0, 0, 3'd0); tick();
    chk("rstseq_pend", int'(io_pending), 3);
    tick();
    drive(0, 4'b0011, 8'h55, 4'b1111, 2'd0, 1, 0, 3'd0); tick();
    chk("rstseq_id1", int'(io_claim_id), 1);
    drive(0, 4'b0011, 8'h55, 4'b1111, 2'd0, 0, 0, 3'd0); tick();
    drive(0, 4'b0011, 8'h55, 4'b1111, 2'd0, 1, 0, 3'd0); tick();
    chk("rstseq_id2", int'(io_claim_id), 2);
    drive(1, 4'b0011, 8'h55, 4'b1111, 2'd0, 0, 0, 3'd0); tick();
    expect_out("rstseq_mid", 4'b0000, 0, 0, 3'd0);
    drive(0, 4'b0011, 8'h55, 4'b1111, 2'd0, 0, 0, 3'd0); tick();
    chk("rstseq_repend", int'(io_pending), 3);

    // Randomized traffic against the reference model.
    drive(1, 4'b0, 8'h0, 4'b0, 2'd0, 0, 0, 3'd0);
    model_step();
    tick();
    for (int n = 0; n < 800; n++) begin
      logic [3:0] ep;
      drive($urandom_range(0, 99) == 0, 4'($urandom), 8'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 2'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            3'($urandom_range(0, 7)));
      model_step();
      tick();
      ep = '0;
      for (int s = 1; s <= NSRC; s++) ep[s-1] = (ms[s] == 1);
      expect_out("rnd", ep, meip, mresp != 0, (mresp != 0) ? 3'(mcid) : 3'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
